// File: rtl/or5_bist_checker.sv
// or5_bist_checker: exhaustive self-test engine for a WIDTH-bit bitwise OR unit.
// Ports: clk/reset (async, active-high); start requests a run (IDLE/DONE only);
// dut_result is the OR unit's answer to op_a/op_b; busy/done/pass report status;
// err_count counts mismatches (saturating); fail_a/fail_b/fail_res hold the first failure.
module or5_bist_checker #(
  parameter int WIDTH  = 5,
  parameter int SETTLE = 1,
  parameter int ERRW   = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dut_result,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERRW-1:0]  err_count,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b,
  output logic [WIDTH-1:0] fail_res
);
  typedef enum logic [1:0] {IDLE, WAIT, CHECK, DONE} state_t;
  localparam logic [3:0] RELOAD = 4'(SETTLE - 1);
  state_t             state;
  logic [2*WIDTH-1:0] idx;
  logic [2*WIDTH-1:0] nxt;
  logic [3:0]         cnt;
  logic               first_seen;
  logic               miss;
  assign nxt  = idx + 1'b1;
  assign miss = dut_result != (op_a | op_b);
  assign pass = done && (err_count == '0);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      cnt        <= '0;
      first_seen <= 1'b0;
      op_a       <= '0;
      op_b       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err_count  <= '0;
      fail_a     <= '0;
      fail_b     <= '0;
      fail_res   <= '0;
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          state      <= WAIT;
          idx        <= '0;
          cnt        <= RELOAD;
          first_seen <= 1'b0;
          op_a       <= '0;
          op_b       <= '0;
          busy       <= 1'b1;
          done       <= 1'b0;
          err_count  <= '0;
          fail_a     <= '0;
          fail_b     <= '0;
          fail_res   <= '0;
        end
        WAIT: if (cnt == '0) state <= CHECK; else cnt <= cnt - 1'b1;
        CHECK: begin
          if (miss && !(&err_count)) err_count <= err_count + 1'b1;
          if (miss && !first_seen) begin
            fail_a     <= op_a;
            fail_b     <= op_b;
            fail_res   <= dut_result;
            first_seen <= 1'b1;
          end
          if (&idx) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            idx   <= nxt;
            op_a  <= nxt[2*WIDTH-1:WIDTH];
            op_b  <= nxt[WIDTH-1:0];
            cnt   <= RELOAD;
            state <= WAIT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_or5_bist_checker.sv
// tb_or5_bist_checker: self-checking bench for or5_bist_checker (default and SETTLE=3/ERRW=4 instances).
module tb_or5_bist_checker;
  typedef struct {
    int inst;
    int mode;
    int dly;
    int cyc;
    int exp_pass;
    int exp_err;
    int fa;
    int fb;
    int fr;
  } row_t;

  localparam int LIM = 5000;

  logic clk = 0;
  logic reset = 0;
  logic start_v [2];
  logic [4:0] oa [2], ob [2], fa [2], fb [2], fr [2], rs [2];
  logic bz [2], dn [2], ps [2];
  logic [11:0] ec [2];
  logic [11:0] ec0;
  logic [3:0] ec1;
  int mode [2];
  int dly;
  logic [4:0] mask [1024];
  logic [4:0] pipe [4];
  int n_chk = 0;
  int n_fail = 0;
  row_t rows [6];

  assign ec[0] = ec0;
  assign ec[1] = {8'b0, ec1};

  always #5 clk = ~clk;

  or5_bist_checker u0 (
    .clk(clk), .reset(reset), .start(start_v[0]), .dut_result(rs[0]),
    .op_a(oa[0]), .op_b(ob[0]), .busy(bz[0]), .done(dn[0]), .pass(ps[0]),
    .err_count(ec0), .fail_a(fa[0]), .fail_b(fb[0]), .fail_res(fr[0])
  );

  or5_bist_checker #(.WIDTH(5), .SETTLE(3), .ERRW(4)) u1 (
    .clk(clk), .reset(reset), .start(start_v[1]), .dut_result(rs[1]),
    .op_a(oa[1]), .op_b(ob[1]), .busy(bz[1]), .done(dn[1]), .pass(ps[1]),
    .err_count(ec1), .fail_a(fa[1]), .fail_b(fb[1]), .fail_res(fr[1])
  );

  // Registered delay line standing in for a slow OR unit on instance 1.
  always @(posedge clk) begin
    pipe[0] <= oa[1] | ob[1];
    for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
  end

  // Unit-under-test behaviour: 0 good, 1 bit 2 stuck at 0, 2 inverted, 3 per-vector fault table.
  function automatic logic [4:0] flt(input int m, input logic [4:0] v, input logic [4:0] a, input logic [4:0] b);
    return m == 1 ? (v & 5'b11011) : m == 2 ? ~v : m == 3 ? (v ^ mask[{a, b}]) : v;
  endfunction

  assign rs[0] = flt(mode[0], oa[0] | ob[0], oa[0], ob[0]);
  assign rs[1] = flt(mode[1], dly == 0 ? (oa[1] | ob[1]) : pipe[2'(dly - 1)], oa[1], ob[1]);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input int k, input string tag);
    chk({tag, "_op_a"}, 32'(oa[k]), 0);
    chk({tag, "_op_b"}, 32'(ob[k]), 0);
    chk({tag, "_busy"}, 32'(bz[k]), 0);
    chk({tag, "_done"}, 32'(dn[k]), 0);
    chk({tag, "_pass"}, 32'(ps[k]), 0);
    chk({tag, "_err"}, 32'(ec[k]), 0);
    chk({tag, "_fail_a"}, 32'(fa[k]), 0);
    chk({tag, "_fail_b"}, 32'(fb[k]), 0);
    chk({tag, "_fail_res"}, 32'(fr[k]), 0);
  endtask

  task automatic wait_done(input int k, output int n);
    n = 0;
    while (!dn[k] && n < LIM) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run(input int k, output int n);
    start_v[k] = 1;
    @(negedge clk);
    start_v[k] = 0;
    wait_done(k, n);
  endtask

  initial begin
    int n, cnt, first, rfa, rfb, rfr;
    start_v[0] = 0;
    start_v[1] = 0;
    mode[0] = 0;
    mode[1] = 0;
    dly = 0;

    // Random per-vector fault table and its expected summary.
    cnt = 0;
    first = -1;
    for (int i = 0; i < 1024; i++) begin
      mask[i] = ($urandom_range(0, 31) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      if (mask[i] != 0) begin
        cnt++;
        if (first < 0) first = i;
      end
    end
    rfa = first < 0 ? 0 : first / 32;
    rfb = first < 0 ? 0 : first % 32;
    rfr = first < 0 ? 0 : int'(5'(rfa | rfb) ^ mask[first]);

    rows[0] = '{0, 0, 0, 2048, 1, 0, 0, 0, 0};
    rows[1] = '{0, 1, 0, 2048, 0, 768, 0, 4, 0};
    rows[2] = '{1, 2, 0, 4096, 0, 15, 0, 0, 31};
    rows[3] = '{1, 0, 2, 4096, 1, 0, 0, 0, 0};
    rows[4] = '{0, 3, 0, 2048, int'(cnt == 0), cnt > 4095 ? 4095 : cnt, rfa, rfb, rfr};
    rows[5] = '{1, 3, 0, 4096, int'(cnt == 0), cnt > 15 ? 15 : cnt, rfa, rfb, rfr};

    // Asynchronous reset between clock edges.
    #2 reset = 1;
    #1;
    chk_zero(0, "rst_async0");
    chk_zero(1, "rst_async1");
    @(negedge clk);
    reset = 0;
    repeat (10) @(negedge clk);
    chk_zero(0, "rst_idle0");
    chk_zero(1, "rst_idle1");

    foreach (rows[i]) begin
      mode[rows[i].inst] = rows[i].mode;
      dly = rows[i].dly;
      run(rows[i].inst, n);
      chk($sformatf("row%0d_cycles", i), n, rows[i].cyc);
      chk($sformatf("row%0d_pass", i), 32'(ps[rows[i].inst]), rows[i].exp_pass);
      chk($sformatf("row%0d_err", i), 32'(ec[rows[i].inst]), rows[i].exp_err);
      chk($sformatf("row%0d_fail_a", i), 32'(fa[rows[i].inst]), rows[i].fa);
      chk($sformatf("row%0d_fail_b", i), 32'(fb[rows[i].inst]), rows[i].fb);
      chk($sformatf("row%0d_fail_res", i), 32'(fr[rows[i].inst]), rows[i].fr);
      chk($sformatf("row%0d_busy", i), 32'(bz[rows[i].inst]), 0);
    end

    // Unit slower than the settle window must be caught.
    mode[1] = 0;
    dly = 4;
    run(1, n);
    chk("dly4_cycles", n, 4096);
    chk("dly4_pass", 32'(ps[1]), 0);
    chk("dly4_err_nonzero", 32'(ec[1] != 0), 1);

    // Start held for three cycles, then re-pulsed mid-run: neither restarts the run.
    mode[0] = 0;
    start_v[0] = 1;
    @(negedge clk);
    n = 0;
    while (!dn[0] && n < LIM) begin
      start_v[0] = (n < 2 || n == 200);
      if (n == 0) chk("ctl_busy_after_start", 32'(bz[0]), 1);
      if (n == 0) chk("ctl_done_cleared", 32'(dn[0]), 0);
      if (n == 1) chk("ctl_vec0_b", 32'(ob[0]), 0);
      if (n == 2) chk("ctl_vec1_b", 32'(ob[0]), 1);
      if (n == 4) chk("ctl_vec2_b", 32'(ob[0]), 2);
      if (n == 128) chk("ctl_vec64_a", 32'(oa[0]), 2);
      @(negedge clk);
      n++;
    end
    start_v[0] = 0;
    chk("ctl_cycles", n, 2048);
    chk("ctl_pass", 32'(ps[0]), 1);
    chk("ctl_last_a", 32'(oa[0]), 31);
    chk("ctl_last_b", 32'(ob[0]), 31);

    // Reset mid-run aborts to all zeros; a fresh start begins at vector (0,0).
    mode[0] = 1;
    start_v[0] = 1;
    @(negedge clk);
    start_v[0] = 0;
    repeat (1000) @(negedge clk);
    chk("mid_busy_before_reset", 32'(bz[0]), 1);
    #2 reset = 1;
    #1;
    chk_zero(0, "mid_reset");
    @(negedge clk);
    reset = 0;
    mode[0] = 0;
    @(negedge clk);
    chk("post_reset_busy", 32'(bz[0]), 0);
    start_v[0] = 1;
    @(negedge clk);
    start_v[0] = 0;
    chk("restart_busy", 32'(bz[0]), 1);
    chk("restart_a", 32'(oa[0]), 0);
    chk("restart_b", 32'(ob[0]), 0);
    chk("restart_err", 32'(ec[0]), 0);
    @(negedge clk);
    @(negedge clk);
    chk("restart_vec1_b", 32'(ob[0]), 1);
    wait_done(0, n);
    chk("restart_cycles", n, 2046);
    chk("restart_pass", 32'(ps[0]), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
